// File: rtl/uc_pkg.sv
// Shared types and constants for the unidade_controle sequencer and its decoder.
package uc_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    // Instruction layout: [7:6] opcode, [5:4] dr, [3:2] sr1, [1:0] sr2, [3:0] imm
    localparam int OPC_HI = 7;
    localparam int OPC_LO = 6;
    localparam int DR_HI  = 5;
    localparam int DR_LO  = 4;
    localparam int SR1_HI = 3;
    localparam int SR1_LO = 2;
    localparam int SR2_HI = 1;
    localparam int SR2_LO = 0;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

endpackage

// File: rtl/unidade_controle_if.sv
// Instruction-memory fetch port: req/addr out of the sequencer, ack/data back.
interface unidade_controle_if #(
    parameter int ADDR_W = 4
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [7:0]        imem_data;

    modport master (output imem_req, imem_addr, input imem_ack, imem_data);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/uc_decoder.sv
// Combinational instruction decoder: IR fields to bank addresses, ALU op and write-back select.
module uc_decoder
    import uc_pkg::*;
(
    input  logic [7:0] ir,
    output logic [1:0] sr1,
    output logic [1:0] sr2,
    output logic [1:0] dr,
    output logic [1:0] alu_op,
    output logic       wb_sel,
    output logic [7:0] imm
);
    logic [1:0] opc;

    assign opc    = ir[OPC_HI:OPC_LO];
    assign sr1    = ir[SR1_HI:SR1_LO];
    assign sr2    = ir[SR2_HI:SR2_LO];
    assign dr     = ir[DR_HI:DR_LO];
    assign wb_sel = (opc == OP_LDI);
    assign imm    = {4'b0000, ir[IMM_HI:IMM_LO]};
    // LDI bypasses the ALU, so its op field is parked at ADD
    assign alu_op = (opc == OP_LDI) ? OP_ADD : opc;
endmodule

// File: rtl/unidade_controle.sv
// Multicycle control unit: fetches prog_len instructions and sequences FETCH/DECODE/EXEC/WB per word.
module unidade_controle
    import uc_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W:0]     prog_len,
    unidade_controle_if.master  imem,
    output logic [1:0]          sr1,
    output logic [1:0]          sr2,
    output logic [1:0]          dr,
    output logic                write,
    output logic [1:0]          alu_op,
    output logic                wb_sel,
    output logic [7:0]          imm,
    output logic                busy,
    output logic                done
);
    state_e          state;
    logic [ADDR_W:0] pc;
    logic [ADDR_W:0] len;
    logic [ADDR_W:0] pc_next;
    logic [7:0]      ir;

    // pc carries one extra bit so a full 2^ADDR_W run terminates instead of wrapping
    assign pc_next = pc + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pc    <= '0;
            len   <= '0;
            ir    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc  <= '0;
                        len <= prog_len;
                        state <= (prog_len != '0) ? S_FETCH : S_DONE;
                    end
                end
                S_FETCH: begin
                    if (imem.imem_ack) begin
                        ir    <= imem.imem_data;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC:   state <= S_WB;
                S_WB: begin
                    pc    <= pc_next;
                    state <= (pc_next == len) ? S_DONE : S_FETCH;
                end
                S_DONE:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign imem.imem_req  = (state == S_FETCH);
    assign imem.imem_addr = pc[ADDR_W-1:0];
    assign write          = (state == S_WB);
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);

    uc_decoder u_dec (
        .ir     (ir),
        .sr1    (sr1),
        .sr2    (sr2),
        .dr     (dr),
        .alu_op (alu_op),
        .wb_sel (wb_sel),
        .imm    (imm)
    );
endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle with a behavioural instruction memory and write monitor.
module tb_unidade_controle;
    localparam int ADDR_W = 4;

    typedef struct packed {
        logic [1:0] dr;
        logic [1:0] sr1;
        logic [1:0] sr2;
        logic [1:0] op;
        logic       wb;
        logic [7:0] imm;
    } wr_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [ADDR_W:0] prog_len = '0;
    logic [1:0]      sr1, sr2, dr, alu_op;
    logic            write, wb_sel, busy, done;
    logic [7:0]      imm;

    unidade_controle_if #(.ADDR_W(ADDR_W)) ifc ();

    unidade_controle #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_len(prog_len), .imem(ifc.master),
        .sr1(sr1), .sr2(sr2), .dr(dr), .write(write), .alu_op(alu_op),
        .wb_sel(wb_sel), .imm(imm), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // memory model: ack after stall_cycles wait cycles when fetching stall_addr
    logic [7:0] mem [16];
    int         stall_addr = -1;
    int         stall_cycles = 0;
    int         wcnt = 0;
    logic       ack_now;
    assign ack_now       = ifc.imem_req && (wcnt >= ((int'(ifc.imem_addr) == stall_addr) ? stall_cycles : 0));
    assign ifc.imem_ack  = ack_now;
    assign ifc.imem_data = mem[ifc.imem_addr];

    always @(posedge clk) begin
        if (ifc.imem_req && !ack_now) wcnt <= wcnt + 1;
        else                          wcnt <= 0;
    end

    // monitor samples pre-edge values
    wr_t wr_q[$];
    int  fetch_cnt [16];
    int  n_done, n_busy, n_req, n_stall, n_bad_wr, cyc, last_wr_cyc, done_cyc, first_addr;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (write) begin
            wr_q.push_back('{dr, sr1, sr2, alu_op, wb_sel, imm});
            last_wr_cyc <= cyc;
        end
        if (write && (reset || !busy)) n_bad_wr <= n_bad_wr + 1;
        if (done) begin n_done <= n_done + 1; done_cyc <= cyc; end
        if (busy) n_busy <= n_busy + 1;
        if (ifc.imem_req) begin
            n_req <= n_req + 1;
            if (!ack_now && int'(ifc.imem_addr) == stall_addr) n_stall <= n_stall + 1;
            if (ack_now) begin
                fetch_cnt[ifc.imem_addr] <= fetch_cnt[ifc.imem_addr] + 1;
                if (first_addr < 0) first_addr <= int'(ifc.imem_addr);
            end
        end
    end

    task automatic clear_mon();
        wr_q.delete();
        for (int i = 0; i < 16; i++) fetch_cnt[i] = 0;
        n_done = 0; n_busy = 0; n_req = 0; n_stall = 0; n_bad_wr = 0;
        last_wr_cyc = -1; done_cyc = -2; first_addr = -1;
    endtask

    // start at the next edge; returns the cycle index (1 = first cycle after start) where done was seen
    task automatic run(input int len, input bit hold_start, output int lat);
        int c;
        @(negedge clk);
        start = 1'b1;
        prog_len = len[ADDR_W:0];
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        prog_len = 5'd5;
        c = 1;
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL run_timeout: no done within %0d cycles", c);
        end
        lat = c;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({ifc.imem_req, write, busy, done} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl: got %b expected 0000", {ifc.imem_req, write, busy, done});
        end
        total++;
        if ({sr1, sr2, dr, alu_op, wb_sel, imm, ifc.imem_addr} !== '0) begin
            bad++; $display("FAIL reset_fields: got %h expected 0", {sr1, sr2, dr, alu_op, wb_sel, imm, ifc.imem_addr});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        wr_t exp [3];
        mem[0] = 8'hC5; mem[1] = 8'hE3; mem[2] = 8'h09;
        exp[0] = '{2'd0, 2'd1, 2'd1, 2'd0, 1'b1, 8'h05};
        exp[1] = '{2'd2, 2'd0, 2'd3, 2'd0, 1'b1, 8'h03};
        exp[2] = '{2'd0, 2'd2, 2'd1, 2'd0, 1'b0, 8'h09};
        clear_mon();
        run(3, 1'b0, lat);
        chk("basic_latency", lat, 13);
        chk("basic_busy_cycles", n_busy, 13);
        chk("basic_writes", wr_q.size(), 3);
        chk("basic_done_count", n_done, 1);
        for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
            total++;
            if (wr_q[i] !== exp[i]) begin
                bad++; $display("FAIL basic_write%0d: got %h expected %h", i, wr_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_stall();
        int lat;
        mem[0] = 8'h49; mem[1] = 8'h96;
        stall_addr = 1; stall_cycles = 3;
        clear_mon();
        run(2, 1'b0, lat);
        stall_addr = -1; stall_cycles = 0;
        chk("stall_latency", lat, 12);
        chk("stall_wait_cycles_addr1", n_stall, 3);
        chk("stall_req_cycles", n_req, 5);
        chk("stall_writes", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            chk("stall_sub_op", int'(wr_q[0].op), 1);
            chk("stall_sub_dr", int'(wr_q[0].dr), 0);
            chk("stall_and_op", int'(wr_q[1].op), 2);
            chk("stall_and_sr", int'({wr_q[1].dr, wr_q[1].sr1, wr_q[1].sr2}), 6'b01_01_10);
        end
    endtask

    task automatic test_zero_len();
        int lat;
        clear_mon();
        run(0, 1'b0, lat);
        chk("zero_latency", lat, 1);
        chk("zero_req", n_req, 0);
        chk("zero_writes", wr_q.size(), 0);
        chk("zero_busy_cycles", n_busy, 1);
    endtask

    task automatic test_full();
        int lat, once;
        for (int i = 0; i < 16; i++) mem[i] = {2'b11, i[1:0], i[3:0]};
        clear_mon();
        run(16, 1'b0, lat);
        chk("full_latency", lat, 65);
        chk("full_writes", wr_q.size(), 16);
        once = 0;
        for (int i = 0; i < 16; i++) if (fetch_cnt[i] == 1) once++;
        chk("full_each_addr_once", once, 16);
        if (wr_q.size() == 16) chk("full_last_imm", int'(wr_q[15].imm), 15);
        chk("full_done_after_last_wb", done_cyc - last_wr_cyc, 1);
    endtask

    task automatic test_reset_mid();
        int c, lat;
        mem[0] = 8'hC5; mem[1] = 8'hE3; mem[2] = 8'h09;
        clear_mon();
        @(negedge clk);
        start = 1'b1; prog_len = 5'd3;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (c < 7) begin @(negedge clk); c++; end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({ifc.imem_req, write, busy, done} !== 4'b0000 ||
            {sr1, sr2, dr, alu_op, wb_sel, imm, ifc.imem_addr} !== '0) begin
            bad++; $display("FAIL midreset_outputs: got %b/%h expected 0000/0",
                {ifc.imem_req, write, busy, done}, {sr1, sr2, dr, alu_op, wb_sel, imm, ifc.imem_addr});
        end
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_writes", wr_q.size(), 1);
        chk("midreset_no_bad_write", n_bad_wr, 0);
        clear_mon();
        run(1, 1'b0, lat);
        chk("restart_latency", lat, 5);
        chk("restart_first_addr", first_addr, 0);
        if (wr_q.size() == 1) chk("restart_imm", int'(wr_q[0].imm), 5);
        else chk("restart_writes", wr_q.size(), 1);
    endtask

    task automatic test_start_busy();
        int lat;
        mem[0] = 8'h09; mem[1] = 8'h49;
        clear_mon();
        run(2, 1'b1, lat);
        repeat (4) @(negedge clk);
        chk("busystart_latency", lat, 9);
        chk("busystart_writes", wr_q.size(), 2);
        chk("busystart_done_count", n_done, 1);
        chk("busystart_fetch_addr2", fetch_cnt[2], 0);
        chk("busystart_idle", int'(busy), 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        cyc = 0;
        clear_mon();
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_full();
        test_reset_mid();
        test_start_busy();
        chk("no_write_outside_wb", n_bad_wr, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end
endmodule
